// File: rtl/mc_control_unit_if.sv
// Control bundle between the multi-cycle control unit and its datapath/memory.
// master: the control unit (reads IR fields and status, drives strobes); slave: the datapath.
interface mc_control_unit_if;
  logic [3:0]  opcode;
  logic [5:0]  func;
  logic        mem_ready;
  logic        bcond;

  logic        pc_write;
  logic        pc_write_cond;
  logic        i_or_d;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        reg_write;
  logic        mem_to_reg;
  logic        output_valid;
  logic        is_halted;
  logic [1:0]  pc_src;
  logic [1:0]  reg_dst;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  imm_sel;
  logic [3:0]  alu_op;
  logic [15:0] num_inst;

  modport master (
    input  opcode, func, mem_ready, bcond,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_write,
           mem_to_reg, output_valid, is_halted, pc_src, reg_dst, alu_src_a, alu_src_b,
           imm_sel, alu_op, num_inst
  );

  modport slave (
    output opcode, func, mem_ready, bcond,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_write,
           mem_to_reg, output_valid, is_halted, pc_src, reg_dst, alu_src_a, alu_src_b,
           imm_sel, alu_op, num_inst
  );
endinterface

// File: rtl/mc_control_unit.sv
// Multi-cycle TSC control FSM (IF/ID/EX/MEM/WB/HLT) with retired-instruction counter.
// Strobes are decoded from the current state and live inputs so memory handshakes take effect same-cycle.
module mc_control_unit (
  input  logic               clk,
  input  logic               reset,
  mc_control_unit_if.master  bus
);

  typedef enum logic [2:0] {StIf, StId, StEx, StMem, StWb, StHlt} state_e;

  localparam logic [3:0] AluAdd = 4'd0;
  localparam logic [3:0] AluOr  = 4'd3;
  localparam logic [3:0] AluLhi = 4'd8;

  state_e      state_q, state_d;
  logic [15:0] num_inst_q;
  logic        retire;

  logic is_branch, is_adi, is_ori, is_lhi, is_lwd, is_swd, is_jmp, is_jal;
  logic is_rtype, is_ralu, is_jpr, is_jrl, is_wwd, is_hlt;

  always_comb begin
    is_branch = (bus.opcode <= 4'd3);
    is_adi    = (bus.opcode == 4'd4);
    is_ori    = (bus.opcode == 4'd5);
    is_lhi    = (bus.opcode == 4'd6);
    is_lwd    = (bus.opcode == 4'd7);
    is_swd    = (bus.opcode == 4'd8);
    is_jmp    = (bus.opcode == 4'd9);
    is_jal    = (bus.opcode == 4'd10);
    is_rtype  = (bus.opcode == 4'd15);
    is_ralu   = is_rtype && (bus.func <= 6'd7);
    is_jpr    = is_rtype && (bus.func == 6'd25);
    is_jrl    = is_rtype && (bus.func == 6'd26);
    is_wwd    = is_rtype && (bus.func == 6'd28);
    is_hlt    = is_rtype && (bus.func == 6'd29);
  end

  always_comb begin
    state_d           = state_q;
    retire            = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.reg_write     = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.output_valid  = 1'b0;
    bus.is_halted     = 1'b0;
    bus.pc_src        = 2'd0;
    bus.reg_dst       = 2'd0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'd0;
    bus.imm_sel       = 2'd0;
    bus.alu_op        = AluAdd;

    // Reset masks every output, including any in-flight memory request.
    if (!reset) begin
      unique case (state_q)
        StIf: begin
          bus.mem_read = 1'b1;
          if (bus.mem_ready) begin
            bus.ir_write = 1'b1;
            bus.pc_write = 1'b1;
            state_d      = StId;
          end
        end

        StId: begin
          if (is_jmp || is_jal) begin
            bus.pc_write = 1'b1;
            bus.pc_src   = 2'd2;
            bus.imm_sel  = 2'd2;
            if (is_jal) begin
              bus.reg_write = 1'b1;
              bus.reg_dst   = 2'd2;
            end
            retire  = 1'b1;
            state_d = StIf;
          end else if (is_jpr || is_jrl) begin
            bus.pc_write = 1'b1;
            bus.pc_src   = 2'd3;
            if (is_jrl) begin
              bus.reg_write = 1'b1;
              bus.reg_dst   = 2'd2;
            end
            retire  = 1'b1;
            state_d = StIf;
          end else if (is_hlt) begin
            retire  = 1'b1;
            state_d = StHlt;
          end else if (is_branch || is_wwd || is_lwd || is_swd || is_adi || is_ori || is_lhi ||
                       is_ralu) begin
            state_d = StEx;
          end else begin
            // Undefined encodings retire as NOPs.
            retire  = 1'b1;
            state_d = StIf;
          end
        end

        StEx: begin
          if (is_branch) begin
            bus.alu_src_b     = 2'd1;
            bus.pc_src        = 2'd1;
            bus.pc_write_cond = 1'b1;
            retire            = 1'b1;
            state_d           = StIf;
          end else if (is_wwd) begin
            bus.output_valid = 1'b1;
            retire           = 1'b1;
            state_d          = StIf;
          end else if (is_lwd || is_swd) begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = 2'd1;
            state_d       = StMem;
          end else begin
            bus.alu_src_a = 1'b1;
            state_d       = StWb;
            if (is_adi) begin
              bus.alu_src_b = 2'd1;
            end else if (is_ori) begin
              bus.alu_src_b = 2'd1;
              bus.imm_sel   = 2'd1;
              bus.alu_op    = AluOr;
            end else if (is_lhi) begin
              bus.alu_src_b = 2'd1;
              bus.imm_sel   = 2'd1;
              bus.alu_op    = AluLhi;
            end else begin
              bus.alu_op = bus.func[3:0];
            end
          end
        end

        StMem: begin
          bus.i_or_d    = 1'b1;
          bus.mem_read  = is_lwd;
          bus.mem_write = !is_lwd;
          if (bus.mem_ready) begin
            if (is_lwd) begin
              state_d = StWb;
            end else begin
              retire  = 1'b1;
              state_d = StIf;
            end
          end
        end

        StWb: begin
          bus.reg_write  = 1'b1;
          bus.reg_dst    = is_rtype ? 2'd0 : 2'd1;
          bus.mem_to_reg = is_lwd;
          retire         = 1'b1;
          state_d        = StIf;
        end

        StHlt: begin
          bus.is_halted = 1'b1;
        end

        default: begin
          state_d = StIf;
        end
      endcase
    end
  end

  always_comb begin
    bus.num_inst = reset ? 16'h0000 : num_inst_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIf;
      num_inst_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (retire) begin
        num_inst_q <= num_inst_q + 16'h0001;
      end
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: decode table, directed multi-cycle sequences and a randomized
// instruction stream checked against per-instruction totals derived from the ISA rules.
module tb_mc_control_unit;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       output_valid;
    logic       is_halted;
    logic [1:0] pc_src;
    logic [1:0] reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_sel;
    logic [3:0] alu_op;
  } ctl_t;

  typedef struct {
    logic [3:0] op;
    logic [5:0] fn;
    logic       bc;
    ctl_t       id_w;
    ctl_t       nx_w;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_bad = 0;

  mc_control_unit_if bus ();

  mc_control_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic ctl_t grab();
    ctl_t s;
    s.pc_write      = bus.pc_write;
    s.pc_write_cond = bus.pc_write_cond;
    s.i_or_d        = bus.i_or_d;
    s.mem_read      = bus.mem_read;
    s.mem_write     = bus.mem_write;
    s.ir_write      = bus.ir_write;
    s.reg_write     = bus.reg_write;
    s.mem_to_reg    = bus.mem_to_reg;
    s.output_valid  = bus.output_valid;
    s.is_halted     = bus.is_halted;
    s.pc_src        = bus.pc_src;
    s.reg_dst       = bus.reg_dst;
    s.alu_src_a     = bus.alu_src_a;
    s.alu_src_b     = bus.alu_src_b;
    s.imm_sel       = bus.imm_sel;
    s.alu_op        = bus.alu_op;
    return s;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Sample mid-cycle, then advance to just after the next rising edge.
  task automatic cyc(output ctl_t s);
    @(negedge clk);
    s = grab();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ctl_t s;
    reset = 1'b1;
    cyc(s);
    reset = 1'b0;
  endtask

  function automatic vec_t mk(input int op, input int fn, input bit bc, input ctl_t a,
                              input ctl_t b);
    vec_t v;
    v.op = 4'(op);
    v.fn = 6'(fn);
    v.bc = bc;
    v.id_w = a;
    v.nx_w = b;
    return v;
  endfunction

  int op_pool[20] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 12, 15, 15, 15, 15, 15, 15, 15, 15};
  int fn_pool[20] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 5, 7, 25, 26, 28, 40};

  initial begin
    ctl_t s, s1, s2;
    ctl_t zero_w, if_w;
    vec_t tbl[$];
    logic [8:0] lw_bits;
    int cnt;
    logic [15:0] n0;

    reset = 1'b1;
    bus.opcode = 4'd0;
    bus.func = 6'd0;
    bus.mem_ready = 1'b0;
    bus.bcond = 1'b0;
    @(posedge clk);
    #1;

    zero_w = '0;
    if_w   = ctl_t'{mem_read: 1'b1, ir_write: 1'b1, pc_write: 1'b1, default: '0};

    // Decode table: expected word in ID, and in the following cycle (EX, or next IF/HLT).
    tbl.push_back(mk(15, 0, 0, zero_w, ctl_t'{alu_src_a: 1'b1, default: '0}));
    tbl.push_back(mk(15, 1, 0, zero_w, ctl_t'{alu_src_a: 1'b1, alu_op: 4'd1, default: '0}));
    tbl.push_back(mk(15, 7, 0, zero_w, ctl_t'{alu_src_a: 1'b1, alu_op: 4'd7, default: '0}));
    tbl.push_back(mk(4, 0, 0, zero_w, ctl_t'{alu_src_a: 1'b1, alu_src_b: 2'd1, default: '0}));
    tbl.push_back(mk(5, 0, 0, zero_w, ctl_t'{alu_src_a: 1'b1, alu_src_b: 2'd1, imm_sel: 2'd1,
                                              alu_op: 4'd3, default: '0}));
    tbl.push_back(mk(6, 0, 0, zero_w, ctl_t'{alu_src_a: 1'b1, alu_src_b: 2'd1, imm_sel: 2'd1,
                                              alu_op: 4'd8, default: '0}));
    tbl.push_back(mk(7, 0, 0, zero_w, ctl_t'{alu_src_a: 1'b1, alu_src_b: 2'd1, default: '0}));
    tbl.push_back(mk(8, 0, 0, zero_w, ctl_t'{alu_src_a: 1'b1, alu_src_b: 2'd1, default: '0}));
    tbl.push_back(mk(1, 0, 0, zero_w, ctl_t'{alu_src_b: 2'd1, pc_src: 2'd1, pc_write_cond: 1'b1,
                                              default: '0}));
    tbl.push_back(mk(2, 0, 1, zero_w, ctl_t'{alu_src_b: 2'd1, pc_src: 2'd1, pc_write_cond: 1'b1,
                                              default: '0}));
    tbl.push_back(mk(9, 0, 0, ctl_t'{pc_write: 1'b1, pc_src: 2'd2, imm_sel: 2'd2, default: '0},
                     if_w));
    tbl.push_back(mk(10, 0, 0, ctl_t'{pc_write: 1'b1, pc_src: 2'd2, imm_sel: 2'd2,
                                      reg_write: 1'b1, reg_dst: 2'd2, default: '0}, if_w));
    tbl.push_back(mk(15, 25, 0, ctl_t'{pc_write: 1'b1, pc_src: 2'd3, default: '0}, if_w));
    tbl.push_back(mk(15, 26, 0, ctl_t'{pc_write: 1'b1, pc_src: 2'd3, reg_write: 1'b1,
                                       reg_dst: 2'd2, default: '0}, if_w));
    tbl.push_back(mk(15, 28, 0, zero_w, ctl_t'{output_valid: 1'b1, default: '0}));
    tbl.push_back(mk(15, 29, 0, zero_w, ctl_t'{is_halted: 1'b1, default: '0}));
    tbl.push_back(mk(12, 0, 0, zero_w, if_w));
    tbl.push_back(mk(15, 40, 0, zero_w, if_w));

    foreach (tbl[i]) begin
      do_reset();
      bus.opcode = tbl[i].op;
      bus.func = tbl[i].fn;
      bus.bcond = tbl[i].bc;
      bus.mem_ready = 1'b1;
      cyc(s);
      if (i == 0) chk("if_word", 64'(s), 64'(if_w));
      cyc(s1);
      chk($sformatf("tbl%0d_id", i), 64'(s1), 64'(tbl[i].id_w));
      cyc(s2);
      chk($sformatf("tbl%0d_next", i), 64'(s2), 64'(tbl[i].nx_w));
    end

    // ADD with zero wait: ir_write in cycle 1, reg_write/rd in cycle 4, one retirement.
    do_reset();
    chk("rst_num", 64'(bus.num_inst), 64'd0);
    bus.opcode = 4'd15;
    bus.func = 6'd0;
    bus.mem_ready = 1'b1;
    cyc(s);
    chk("add_c1_irw", 64'(s.ir_write), 64'd1);
    cyc(s);
    cyc(s);
    cyc(s);
    chk("add_c4_wb", 64'({s.reg_write, s.reg_dst}), 64'({1'b1, 2'd0}));
    chk("add_num", 64'(bus.num_inst), 64'd1);

    // LWD with two wait cycles in IF and in MEM: 9 cycles, write-back only in the last.
    do_reset();
    bus.opcode = 4'd7;
    bus.func = 6'd0;
    lw_bits = '0;
    for (int k = 0; k < 9; k++) begin
      bus.mem_ready = (k == 2 || k == 7);
      cyc(s);
      lw_bits[k] = s.mem_to_reg & s.reg_write;
      if (k == 7) chk("lwd_num8", 64'(bus.num_inst), 64'd0);
    end
    chk("lwd_wb_bits", 64'(lw_bits), 64'h100);
    chk("lwd_num9", 64'(bus.num_inst), 64'd1);

    // Two BEQs: PC source/cond strobe in both EX cycles, retire regardless of bcond.
    do_reset();
    bus.opcode = 4'd1;
    bus.mem_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      bus.bcond = b[0];
      cyc(s);
      cyc(s);
      cyc(s);
      chk($sformatf("beq%0d_ex", b), 64'({s.pc_write_cond, s.pc_src, s.pc_write}),
          64'({1'b1, 2'd1, 1'b0}));
    end
    chk("beq_num", 64'(bus.num_inst), 64'd2);

    // JAL then WWD: output_valid pulses once across WWD and the following fetch.
    do_reset();
    bus.opcode = 4'd10;
    cyc(s);
    cyc(s);
    chk("jal_id", 64'({s.pc_write, s.pc_src, s.imm_sel, s.reg_dst}),
        64'({1'b1, 2'd2, 2'd2, 2'd2}));
    bus.opcode = 4'd15;
    bus.func = 6'd28;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      cyc(s);
      cnt += int'(s.output_valid);
    end
    chk("wwd_ov_cnt", 64'(cnt), 64'd1);

    // HLT: halted and frozen, reset forces outputs low and restarts a fetch.
    do_reset();
    bus.func = 6'd29;
    bus.mem_ready = 1'b1;
    cyc(s);
    cyc(s);
    n0 = bus.num_inst;
    chk("hlt_num", 64'(n0), 64'd1);
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      bus.mem_ready = 1'($urandom_range(0, 1));
      cyc(s);
      cnt += int'(s.is_halted && (64'(s) == 64'(ctl_t'{is_halted: 1'b1, default: '0})));
      if (bus.num_inst != 16'd1) cnt = -100;
    end
    chk("hlt_hold", 64'(cnt), 64'd12);
    reset = 1'b1;
    cyc(s);
    chk("hlt_rst_out", 64'(s), 64'd0);
    chk("hlt_rst_num", 64'(bus.num_inst), 64'd0);
    reset = 1'b0;
    bus.mem_ready = 1'b0;
    cyc(s);
    chk("hlt_post_if", 64'({s.mem_read, s.i_or_d, s.is_halted}), 64'({1'b1, 1'b0, 1'b0}));

    // Reset in the middle of a MEM wait abandons the load.
    do_reset();
    bus.opcode = 4'd7;
    bus.func = 6'd0;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      bus.mem_ready = (k == 0);
      cyc(s);
    end
    chk("mem_wait_rd", 64'({s.mem_read, s.i_or_d}), 64'({1'b1, 1'b1}));
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    cyc(s);
    cnt += int'(s.reg_write) + int'(s.mem_read);
    reset = 1'b0;
    bus.mem_ready = 1'b0;
    cyc(s);
    cnt += int'(s.reg_write);
    chk("abandon_if", 64'({s.mem_read, s.i_or_d, s.ir_write}), 64'({1'b1, 1'b0, 1'b0}));
    chk("abandon_misc", 64'({16'(cnt), bus.num_inst}), 64'd0);

    // Randomized instruction stream against per-instruction totals.
    do_reset();
    for (int n = 0; n < 200; n++) begin
      int p, op, fn, w_if, w_mem, lat, mem_at;
      bit jmp, br, wwd, alu, lwd, swd;
      int c_ir, c_rw, c_mr, c_mw, c_ov, c_pw, c_pwc;
      logic [15:0] exp_num;
      p = $urandom_range(0, 19);
      op = op_pool[p];
      fn = fn_pool[p];
      w_if = $urandom_range(0, 3);
      w_mem = $urandom_range(0, 3);
      jmp = (op == 9 || op == 10 || (op == 15 && (fn == 25 || fn == 26)));
      br = (op <= 3);
      wwd = (op == 15 && fn == 28);
      alu = ((op >= 4 && op <= 6) || (op == 15 && fn <= 7));
      lwd = (op == 7);
      swd = (op == 8);
      lat = lwd ? 5 : (swd || alu) ? 4 : (br || wwd) ? 3 : 2;
      lat += w_if + ((lwd || swd) ? w_mem : 0);
      mem_at = w_if + 3;
      exp_num = bus.num_inst + 16'd1;
      bus.opcode = 4'(op);
      bus.func = 6'(fn);
      {c_ir, c_rw, c_mr, c_mw, c_ov, c_pw, c_pwc} = '0;
      for (int k = 0; k < lat; k++) begin
        if (k < w_if) bus.mem_ready = 1'b0;
        else if (k == w_if) bus.mem_ready = 1'b1;
        else if ((lwd || swd) && k >= mem_at && k < mem_at + w_mem) bus.mem_ready = 1'b0;
        else if ((lwd || swd) && k == mem_at + w_mem) bus.mem_ready = 1'b1;
        else bus.mem_ready = 1'($urandom_range(0, 1));
        bus.bcond = 1'($urandom_range(0, 1));
        cyc(s);
        c_ir += int'(s.ir_write);
        c_rw += int'(s.reg_write);
        c_mr += int'(s.mem_read);
        c_mw += int'(s.mem_write);
        c_ov += int'(s.output_valid);
        c_pw += int'(s.pc_write);
        c_pwc += int'(s.pc_write_cond);
      end
      chk($sformatf("rnd%0d_op%0d_f%0d_cnt", n, op, fn),
          {8'(c_ir), 8'(c_rw), 8'(c_mr), 8'(c_mw), 8'(c_ov), 8'(c_pw), 8'(c_pwc)},
          {8'd1, 8'(jmp && (op == 10 || fn == 26) || alu || lwd),
           8'(w_if + 1 + (lwd ? w_mem + 1 : 0)), 8'(swd ? w_mem + 1 : 0), 8'(wwd),
           8'(1 + int'(jmp)), 8'(br)});
      chk($sformatf("rnd%0d_num", n), 64'(bus.num_inst), 64'(exp_num));
    end

    // Counter wrap: 65535 JMPs reach FFFF, one more returns to zero.
    do_reset();
    bus.opcode = 4'd9;
    bus.mem_ready = 1'b1;
    for (int k = 0; k < 2 * 65535; k++) cyc(s);
    chk("wrap_ffff", 64'(bus.num_inst), 64'hFFFF);
    cyc(s);
    cyc(s);
    chk("wrap_zero", 64'(bus.num_inst), 64'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
